v_loadunit: RTL and testbench

//  Vector load unit: executes vle8/16/32 and vlse8/16/32 against the 4-read-port data memory.

---
 rtl/v_loadunit.sv | 188 ++++++++++++++++++
 tb/tb_v_loadunit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/v_loadunit.sv
// Vector load unit: issues up to 4 element reads per cycle for vle/vlse 8/16/32 and packs them into a 512-bit image.
// Latency: rd_en cycles 1..N after the start edge, done pulses in cycle N+2 (cycle 1 for an invalid op/lmul).
// Backpressure: none; start is ignored while busy, memory is assumed to answer every read the next cycle.
// Optional build macro VLOAD_ZERO_TAIL_EN: accepted starts clear data_out above NE*EEW instead of leaving it undisturbed.
module v_loadunit #(
    parameter int ADDR_W = 14,
    parameter int WORD_W = 32,
    parameter int VREG_W = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [3:0]        load_op,
    input  logic [2:0]        lmul,
    input  logic [4:0]        stride,
    input  logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] data_addr0,
    output logic [ADDR_W-1:0] data_addr1,
    output logic [ADDR_W-1:0] data_addr2,
    output logic [ADDR_W-1:0] data_addr3,
    output logic              rd_en,
    input  logic [WORD_W-1:0] data_in0,
    input  logic [WORD_W-1:0] data_in1,
    input  logic [WORD_W-1:0] data_in2,
    input  logic [WORD_W-1:0] data_in3,
    output logic [VREG_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int OFF_W = $clog2(VREG_W);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    // latched operation parameters
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        stride_q;
    logic [1:0]        eew_q;      // 0:8 1:16 2:32 bit elements
    logic [3:0]        last_k;
    logic [3:0]        beat_k;

    // capture pipeline: one beat behind issue
    logic              cap_vld;
    logic [3:0]        cap_k;
    logic [3:0][1:0]   lane_q;

    logic              op_ok;
    logic              op_strided;
    logic [1:0]        op_eew;
    logic [3:0]        op_last;

    logic [3:0][ADDR_W-1:0] byte_addr;
    logic [3:0][WORD_W-1:0] rdata;
    logic [3:0][WORD_W-1:0] cap_elem;
    logic [3:0][OFF_W-1:0]  cap_off;

    assign rdata = {data_in3, data_in2, data_in1, data_in0};

    // decode load_op/lmul into element width, addressing mode and beat count
    always_comb begin
        op_ok      = 1'b0;
        op_strided = 1'b0;
        op_eew     = 2'd0;
        case (load_op)
            4'd1, 4'd2, 4'd3: begin
                op_ok  = 1'b1;
                op_eew = 2'(load_op - 4'd1);
            end
            4'd4, 4'd5, 4'd6: begin
                op_ok      = 1'b1;
                op_strided = 1'b1;
                op_eew     = 2'(load_op - 4'd4);
            end
            default: op_ok = 1'b0;
        endcase
        if (lmul > 3'd2) op_ok = 1'b0;
        // beats = (4 << lmul) >> eew, i.e. NE/4
        op_last = 4'(((5'd4 << lmul[1:0]) >> op_eew) - 5'd1);
    end

    // state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and status outputs
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = op_ok ? ISSUE : DONE;
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (beat_k == last_k) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // byte address of element 4k+j: base + idx*stride*bytes, wrapping at ADDR_W
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            byte_addr[j] = base_q
                + ((ADDR_W'({beat_k, 2'(j)}) * ADDR_W'(stride_q)) << eew_q);
        end
    end

    assign data_addr0 = rd_en ? ADDR_W'(byte_addr[0][ADDR_W-1:2]) : '0;
    assign data_addr1 = rd_en ? ADDR_W'(byte_addr[1][ADDR_W-1:2]) : '0;
    assign data_addr2 = rd_en ? ADDR_W'(byte_addr[2][ADDR_W-1:2]) : '0;
    assign data_addr3 = rd_en ? ADDR_W'(byte_addr[3][ADDR_W-1:2]) : '0;

    // lane-align returned words (zero-fill above the word) and locate each element in the image
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            cap_elem[j] = rdata[j] >> {lane_q[j], 3'b000};
            case (eew_q)
                2'd0:    cap_off[j] = OFF_W'({cap_k, 2'(j), 3'b000});
                2'd1:    cap_off[j] = OFF_W'({cap_k[2:0], 2'(j), 4'b0000});
                default: cap_off[j] = OFF_W'({cap_k[1:0], 2'(j), 5'b00000});
            endcase
        end
    end

`ifdef VLOAD_ZERO_TAIL_EN
    logic [VREG_W-1:0] tail_keep;

    // ones over the NE*EEW = 128<<lmul body bits
    always_comb tail_keep = {VREG_W{1'b1}} >> (VREG_W - (128 << lmul[1:0]));
`endif

    // operation latch, beat counter, capture pipeline and result image
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            base_q   <= '0;
            stride_q <= '0;
            eew_q    <= '0;
            last_k   <= '0;
            beat_k   <= '0;
            cap_vld  <= 1'b0;
            cap_k    <= '0;
            lane_q   <= '0;
            data_out <= '0;
        end else begin
            cap_vld <= (state == ISSUE);
            if (state == ISSUE) begin
                cap_k  <= beat_k;
                beat_k <= beat_k + 4'd1;
                for (int j = 0; j < 4; j++) lane_q[j] <= byte_addr[j][1:0];
            end
            if (start && state == IDLE && op_ok) begin
                base_q   <= address;
                stride_q <= op_strided ? stride : 5'd1;
                eew_q    <= op_eew;
                last_k   <= op_last;
                beat_k   <= '0;
`ifdef VLOAD_ZERO_TAIL_EN
                data_out <= data_out & tail_keep;
`endif
            end
            if (cap_vld) begin
                for (int j = 0; j < 4; j++) begin
                    case (eew_q)
                        2'd0:    data_out[cap_off[j] +: 8]  <= cap_elem[j][7:0];
                        2'd1:    data_out[cap_off[j] +: 16] <= cap_elem[j][15:0];
                        default: data_out[cap_off[j] +: 32] <= cap_elem[j][31:0];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_v_loadunit.sv
// Testbench for v_loadunit: directed examples plus random ops against a behavioural model.
// Latency: model expects rd_en for N cycles from cycle 1 and done in cycle N+2 (cycle 1 if invalid).
// Backpressure: none; a second start pulsed while busy must be ignored.
module tb_v_loadunit;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic [3:0]   load_op;
    logic [2:0]   lmul;
    logic [4:0]   stride;
    logic [13:0]  address;
    logic [13:0]  data_addr0, data_addr1, data_addr2, data_addr3;
    logic         rd_en;
    logic [31:0]  data_in0, data_in1, data_in2, data_in3;
    logic [511:0] data_out;
    logic         busy;
    logic         done;

    logic [31:0]  mem [4096];
    logic [511:0] exp_out;
    logic [511:0] ramp;
    int           vec_cnt = 0;
    int           err_cnt = 0;

    v_loadunit dut (
        .clk(clk), .nrst(nrst), .start(start), .load_op(load_op), .lmul(lmul),
        .stride(stride), .address(address),
        .data_addr0(data_addr0), .data_addr1(data_addr1),
        .data_addr2(data_addr2), .data_addr3(data_addr3),
        .rd_en(rd_en),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // 4-port synchronous-read data memory
    always @(posedge clk) begin
        data_in0 <= mem[data_addr0[13:2] == 12'd0 ? data_addr0[11:0] : data_addr0[11:0]];
        data_in1 <= mem[data_addr1[11:0]];
        data_in2 <= mem[data_addr2[11:0]];
        data_in3 <= mem[data_addr3[11:0]];
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected result image after one load, from the element address rules.
    task automatic model(input logic [3:0] op, input logic [2:0] lm, input logic [4:0] st,
                         input logic [13:0] ad);
        int eb, ne, s;
        logic [13:0] ba;
        logic [31:0] v;
        if (!(op >= 1 && op <= 6 && lm <= 2)) return;
        eb = 1 << ((int'(op) - 1) % 3);
        ne = (128 << lm) / (8 * eb);
        s  = (op >= 4) ? int'(st) : 1;
`ifdef VLOAD_ZERO_TAIL_EN
        for (int b = 128 << lm; b < 512; b++) exp_out[b] = 1'b0;
`endif
        for (int i = 0; i < ne; i++) begin
            ba = 14'(int'(ad) + i * s * eb);
            v  = mem[ba[13:2]] >> (8 * int'(ba[1:0]));
            for (int b = 0; b < 8 * eb; b++) exp_out[i * 8 * eb + b] = v[b];
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [2:0] lm, input logic [4:0] st,
                          input logic [13:0] ad, input bit poke);
        bit valid;
        int eb, s, nb, rdcnt, done_cyc;
        logic [13:0] ba;
        logic [13:0] got_a [4];
        valid = (op >= 1 && op <= 6 && lm <= 2);
        eb = valid ? (1 << ((int'(op) - 1) % 3)) : 1;
        nb = valid ? ((128 << lm) / (8 * eb)) / 4 : 0;
        s  = (op >= 4) ? int'(st) : 1;
        model(op, lm, st, ad);
        @(negedge clk);
        load_op = op; lmul = lm; stride = st; address = ad; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdcnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (poke && cyc == 2) begin
                load_op = 4'd3; lmul = 3'd0; address = 14'h0100; start = 1'b1;
            end
            if (poke && cyc == 3) start = 1'b0;
            if (rd_en) begin
                got_a = '{data_addr0, data_addr1, data_addr2, data_addr3};
                for (int j = 0; j < 4; j++) begin
                    ba = 14'(int'(ad) + (4 * rdcnt + j) * s * eb);
                    check($sformatf("addr k%0d p%0d", rdcnt, j), 512'(got_a[j]), 512'({2'b00, ba[13:2]}));
                end
                rdcnt++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("done_cycle op%0d lmul%0d", op, lm), 512'(done_cyc), 512'(valid ? nb + 2 : 1));
        check("rd_en_cycles", 512'(rdcnt), 512'(nb));
        check($sformatf("data_out op%0d lmul%0d st%0d ad%0h", op, lm, st, ad), data_out, exp_out);
        @(negedge clk);
        check("done_after", 512'(done), 512'(0));
        check("busy_after", 512'(busy), 512'(0));
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [2:0]  r_lm;
        logic [13:0] r_ad;
        for (int w = 0; w < 4096; w++) mem[w] = (w < 16) ? {4{8'(w * 17)}} : $urandom;
        for (int w = 0; w < 16; w++) ramp[w * 32 +: 32] = {4{8'(w * 17)}};
        nrst = 1'b0; start = 1'b0; load_op = '0; lmul = '0; stride = '0; address = '0;
        exp_out = '0;
        repeat (2) @(negedge clk);
        check("rst data_out", data_out, 512'(0));
        check("rst rd_en", 512'(rd_en), 512'(0));
        check("rst busy", 512'(busy), 512'(0));
        check("rst done", 512'(done), 512'(0));
        check("rst data_addr0", 512'(data_addr0), 512'(0));
        nrst = 1'b1;

        run_op(4'd3, 3'd0, 5'd0, 14'd0, 1'b0);
        check("vle32 m1 low", 512'(data_out[127:0]), 512'(128'h33333333_22222222_11111111_00000000));
        run_op(4'd3, 3'd2, 5'd0, 14'd0, 1'b0);
        check("vle32 m4 ramp", data_out, ramp);
        run_op(4'd3, 3'd0, 5'd0, 14'd0, 1'b0);
`ifdef VLOAD_ZERO_TAIL_EN
        check("tail zeroed", 512'(data_out[511:128]), 512'(0));
`else
        check("tail kept", 512'(data_out[511:128]), 512'(ramp[511:128]));
`endif
        run_op(4'd6, 3'd0, 5'd2, 14'd0, 1'b0);
        check("vlse32 st2 low", 512'(data_out[127:0]), 512'(128'h66666666_44444444_22222222_00000000));
        run_op(4'd1, 3'd0, 5'd0, 14'd4, 1'b0);
        check("vle8 a4 low", 512'(data_out[127:0]), 512'(128'h44444444_33333333_22222222_11111111));

        // abort mid-operation with reset
        @(negedge clk);
        load_op = 4'd3; lmul = 3'd2; address = 14'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("abort rd_en", 512'(rd_en), 512'(0));
        check("abort busy", 512'(busy), 512'(0));
        check("abort done", 512'(done), 512'(0));
        check("abort data_out", data_out, 512'(0));
        @(negedge clk);
        nrst = 1'b1;
        exp_out = '0;
        run_op(4'd3, 3'd0, 5'd0, 14'd0, 1'b0);

        // invalid ops, stride 0, misaligned elements, start while busy
        run_op(4'd0, 3'd0, 5'd0, 14'd0, 1'b0);
        run_op(4'd9, 3'd1, 5'd0, 14'd0, 1'b0);
        run_op(4'd2, 3'd3, 5'd0, 14'd0, 1'b0);
        run_op(4'd5, 3'd1, 5'd0, 14'h0123, 1'b0);
        run_op(4'd3, 3'd0, 5'd0, 14'h0003, 1'b0);
        run_op(4'd2, 3'd1, 5'd0, 14'h0011, 1'b1);
        run_op(4'd6, 3'd2, 5'd31, 14'h3ff0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_op = 4'($urandom_range(0, 8));
            r_lm = 3'(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2));
            r_ad = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 63)) : 14'($urandom);
            run_op(r_op, r_lm, 5'($urandom), r_ad, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
